// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the RV32 CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Fetch stage state encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_target_adder.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_adder
// Description : Combinational pc + (imm << 1) with a word-misalignment flag.
//               The immediate holds a halfword offset, so it is scaled by two.
//               The sum wraps modulo 2^ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_adder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] imm_i,
  output logic [ADDR_W-1:0]  target_o,
  output logic               misalign_o
);

  logic [INSTR_W-1:0] w_imm_sh;

  // Scale the halfword offset to bytes and add to the branching PC
  always_comb begin
    w_imm_sh   = imm_i << 1;
    target_o   = pc_i + ADDR_W'(w_imm_sh);
    misalign_o = target_o[1];
  end

endmodule : branch_target_adder
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32 instruction fetch stage. Owns the PC, issues word
//               requests over a req/ack handshake and hands instructions to
//               decode over valid/ready. Redirects take priority over all
//               other events; a request already in flight is allowed to
//               complete and its data is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [INSTR_W-1:0] redirect_imm,
  output logic               misalign_err
);

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               imem_req_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               misalign_q;

  logic [ADDR_W-1:0]  w_tgt_raw;
  logic               w_tgt_mis;
  logic [ADDR_W-1:0]  tgt_d;

  branch_target_adder #(
    .ADDR_W (ADDR_W)
  ) u_bta (
    .pc_i       (redirect_pc),
    .imm_i      (redirect_imm),
    .target_o   (w_tgt_raw),
    .misalign_o (w_tgt_mis)
  );

  // A misaligned target is forced back onto a word boundary
  always_comb begin
    tgt_d = w_tgt_raw;
    if (w_tgt_mis) begin
      tgt_d[1:0] = 2'b00;
    end
  end

  // Fetch FSM with all handshake outputs registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      pc_q          <= c_reset_pc;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= c_reset_pc;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      if (redirect_en && w_tgt_mis) begin
        misalign_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (redirect_en) begin
            pc_q <= tgt_d;
          end else begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end
        end

        S_REQ: begin
          if (redirect_en) begin
            pc_q <= tgt_d;
            if (imem_ack) begin
              // Data for the old PC is dropped; re-issue at the target
              imem_addr_q <= tgt_d;
            end else begin
              // Outstanding request must finish with addr held stable
              state_q <= S_DROP;
            end
          end else if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            pc_q          <= pc_q + ADDR_W'(4);
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_VALID;
          end
        end

        S_VALID: begin
          if (redirect_en) begin
            pc_q          <= tgt_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= tgt_d;
            state_q       <= S_REQ;
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= pc_q;
            state_q       <= S_REQ;
          end
        end

        S_DROP: begin
          if (redirect_en) begin
            pc_q <= tgt_d;
          end else if (imem_ack) begin
            imem_addr_q <= pc_q;
            state_q     <= S_REQ;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;
  logic        misalign_err;

  logic        ack_on;
  int          n_checks;
  int          n_fail;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .redirect_imm (redirect_imm),
    .misalign_err (misalign_err)
  );

  // Memory model: acknowledges a live request whenever ack_on is set
  assign imem_ack = imem_req & ack_on;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rstn         = 1'b0;
    ack_on       = 1'b1;
    imem_rdata   = 32'h0050_0093;
    instr_ready  = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = '0;
    redirect_imm = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_req",   {31'd0, imem_req},     32'd0);
    check_eq("rst_addr",  imem_addr,             32'h0);
    check_eq("rst_valid", {31'd0, instr_valid},  32'd0);
    check_eq("rst_instr", instr,                 32'h0000_0013);
    check_eq("rst_ipc",   instr_pc,              32'h0);
    check_eq("rst_err",   {31'd0, misalign_err}, 32'd0);

    // First fetch: request one cycle after release, data the cycle after
    rstn = 1'b1;
    tick();
    check_eq("first_req",  {31'd0, imem_req},    32'd1);
    check_eq("first_addr", imem_addr,            32'h0);
    tick();
    check_eq("first_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("first_instr", instr,                32'h0050_0093);
    check_eq("first_ipc",   instr_pc,             32'h0);
    check_eq("first_noreq", {31'd0, imem_req},    32'd0);

    // Back-pressure for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("bp_instr", instr,                32'h0050_0093);
      check_eq("bp_ipc",   instr_pc,             32'h0);
      check_eq("bp_noreq", {31'd0, imem_req},    32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    ack_on      = 1'b0;
    check_eq("bp_next_req",  {31'd0, imem_req},    32'd1);
    check_eq("bp_next_addr", imem_addr,            32'h4);
    check_eq("bp_next_vld",  {31'd0, instr_valid}, 32'd0);

    // Four wait states, request held stable
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("ws_req",   {31'd0, imem_req},    32'd1);
      check_eq("ws_addr",  imem_addr,            32'h4);
      check_eq("ws_valid", {31'd0, instr_valid}, 32'd0);
    end
    ack_on     = 1'b1;
    imem_rdata = 32'h00A0_0113;
    tick();
    ack_on = 1'b0;
    check_eq("ws_dvalid", {31'd0, instr_valid}, 32'd1);
    check_eq("ws_instr",  instr,                32'h00A0_0113);
    check_eq("ws_ipc",    instr_pc,             32'h4);
    check_eq("ws_noreq",  {31'd0, imem_req},    32'd0);

    // beq redirect while holding a valid instruction: 0x10 + (-4 << 1) = 0x08
    redirect_en  = 1'b1;
    redirect_pc  = 32'h10;
    redirect_imm = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    check_eq("beq_valid", {31'd0, instr_valid},  32'd0);
    check_eq("beq_req",   {31'd0, imem_req},     32'd1);
    check_eq("beq_addr",  imem_addr,             32'h8);
    check_eq("beq_err",   {31'd0, misalign_err}, 32'd0);

    // Redirect with request outstanding: 0x20 + (0x10 << 1) = 0x40
    redirect_en  = 1'b1;
    redirect_pc  = 32'h20;
    redirect_imm = 32'h0000_0010;
    tick();
    redirect_en = 1'b0;
    check_eq("drop_req",  {31'd0, imem_req},    32'd1);
    check_eq("drop_addr", imem_addr,            32'h8);
    tick();
    check_eq("drop_hold", imem_addr,            32'h8);
    check_eq("drop_vld0", {31'd0, instr_valid}, 32'd0);
    ack_on     = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    ack_on = 1'b0;
    check_eq("drop_vld1", {31'd0, instr_valid}, 32'd0);
    check_eq("drop_req2", {31'd0, imem_req},    32'd1);
    check_eq("drop_new",  imem_addr,            32'h40);
    ack_on     = 1'b1;
    imem_rdata = 32'h0000_0513;
    tick();
    ack_on = 1'b0;
    check_eq("tgt_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("tgt_instr", instr,                32'h0000_0513);
    check_eq("tgt_ipc",   instr_pc,             32'h40);

    // Misaligned jal: 0 + (1 << 1) = 2 -> flag, fetch at 0
    redirect_en  = 1'b1;
    redirect_pc  = 32'h0;
    redirect_imm = 32'h0000_0001;
    tick();
    redirect_en = 1'b0;
    check_eq("mis_err",   {31'd0, misalign_err}, 32'd1);
    check_eq("mis_addr",  imem_addr,             32'h0);
    check_eq("mis_valid", {31'd0, instr_valid},  32'd0);
    ack_on      = 1'b1;
    instr_ready = 1'b1;
    tick();
    check_eq("mis_ipc",  instr_pc,              32'h0);
    check_eq("mis_err2", {31'd0, misalign_err}, 32'd1);
    ack_on = 1'b0;
    tick();
    instr_ready = 1'b0;
    check_eq("mis_next", imem_addr,             32'h4);
    check_eq("mis_err3", {31'd0, misalign_err}, 32'd1);
    check_eq("mis_req",  {31'd0, imem_req},     32'd1);

    // Asynchronous reset in the middle of an outstanding request
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_req",  {31'd0, imem_req},     32'd0);
    check_eq("arst_err",  {31'd0, misalign_err}, 32'd0);
    check_eq("arst_addr", imem_addr,             32'h0);
    check_eq("arst_vld",  {31'd0, instr_valid},  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32 CPU. Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Presents the fetched instruction and its PC to decode and immediate expansion through a valid/ready handshake.
- Consumes the sign-extended branch/jump immediate, which holds a halfword offset. It computes redirect targets as PC + (imm << 1).

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- ADDR_W, 32, width of PC and instruction-memory address.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_W  word address of the request (PC).
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- instr  out  32  instruction word to decode and immediate expansion.
- instr_pc  out  ADDR_W  PC of instr.
- redirect_en  in  1  taken beq or jal this cycle.
- redirect_pc  in  ADDR_W  PC of the branching instruction.
- redirect_imm  in  32  sign-extended halfword offset.
- misalign_err  out  1  sticky: a redirect target had bit 1 set.

Behaviour:
- Reset (rstn=0, asynchronous): state=S_IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (nop), instr_pc=0, misalign_err=0.
- States: S_IDLE, S_REQ, S_VALID, S_DROP.
  - imem_req=1 in S_REQ and S_DROP.
  - instr_valid=1 only in S_VALID.
  - imem_addr is registered and equals pc in S_REQ.
- S_IDLE: next cycle goes to S_REQ. The first request appears one cycle after reset release.
- S_REQ, imem_ack=1, no redirect: register instr=imem_rdata, instr_pc=pc, pc=pc+4, then go to S_VALID. Minimum 1 cycle from req to valid.
- S_REQ, imem_ack=0: hold req and addr stable; stay in S_REQ.
- S_VALID, instr_ready=1: go to S_REQ and fetch the next pc. Steady-state throughput is 1 instruction per 2 cycles with a zero-wait memory.
- S_VALID, instr_ready=0: hold instr, instr_pc and instr_valid unchanged.
- Redirect target: redirect_pc + (redirect_imm << 1), computed in 32 bits and wrapping modulo 2^32. No overflow flag.
- Misaligned target: if target[1]=1, set misalign_err (sticky until reset) and load target with bits[1:0] cleared.
- Redirect has priority over every other event:
  - In S_VALID: drop the held instruction (instr_valid=0 next cycle), set pc=target, go to S_REQ.
  - In S_REQ with imem_ack=1 the same cycle: discard rdata, set pc=target, go to S_REQ.
  - In S_REQ with imem_ack=0: the outstanding request must complete. Keep req and the old addr stable, latch the target into pc, go to S_DROP.
  - In S_DROP or S_IDLE: overwrite pc with the new target and keep the current state.
- S_DROP, imem_ack=1: discard rdata, go to S_REQ with the redirected pc. With imem_ack=0, stay in S_DROP.
- Mid-operation reset: abandon any outstanding request immediately. Memory must tolerate req falling without ack.
- instr_ready is ignored outside S_VALID.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding constants: S_IDLE=2'd0, S_REQ=2'd1, S_VALID=2'd2, S_DROP=2'd3.
  - NOP_INSTR=32'h0000_0013.
  - INSTR_W=32.
- One natural sub-module: branch_target_adder. It is combinational: pc + (imm << 1), plus the misalign flag. Decode/execute can reuse it for the jal link/target path.

Test Plan:
- Reset release with RESET_PC=0 and zero-wait memory returning 32'h00500093 → imem_req rises 1 cycle after rstn high with addr 0. instr_valid=1 next cycle with instr=32'h00500093, instr_pc=0. The next request has addr 4.
- Back-pressure: instr_ready=0 for 3 cycles in S_VALID → instr and instr_pc stable, no new imem_req. On instr_ready=1, the next request addr equals instr_pc+4.
- Wait-state memory: imem_ack delayed 4 cycles → imem_req and imem_addr stable for all 4 cycles, then exactly one instruction delivered.
- beq redirect in S_VALID with redirect_pc=32'h10, redirect_imm=32'hFFFF_FFFC → held instruction dropped, next imem_addr=32'h08, misalign_err=0.
- Redirect during an outstanding request (imem_ack=0), redirect_pc=32'h20, redirect_imm=32'h0000_0010 → the request for the old addr completes and its data is discarded (instr_valid never rises). The next request has addr 32'h40.
- Misaligned jal with redirect_pc=0, redirect_imm=32'h1 → misalign_err=1 and stays 1 across later fetches, next imem_addr=0. Asserting rstn=0 mid-request → imem_req=0 and misalign_err=0 immediately.
